// File: rtl/sm_controller.sv
// -----------------------------------------------------------------------------
// sm_controller
// Moore control FSM that sequences a register file and datapath for a small
// instruction set (MOV imm, MOV reg, ADD, CMP, AND, MVN).
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   s         in   start request, honoured only while waiting
//   in[15:0]  in   instruction word, latched when s is accepted
//   w         out  ready, high only while waiting
//   readnum   out  register-file read index
//   writenum  out  register-file write index
//   write     out  register-file write enable (one cycle per writing instr)
//   loada/b/c out  datapath A/B/C register enables
//   loads     out  status register enable
//   asel      out  forces ALU A input to zero
//   vsel      out  write-back source select (0 = C, 1 = sximm8)
//   sximm8    out  sign-extended instr[7:0]
//   shift     out  instr[4:3]
//   aluop     out  instr[12:11]
// -----------------------------------------------------------------------------
module sm_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        vsel,
    output logic [15:0] sximm8,
    output logic [1:0]  shift,
    output logic [1:0]  aluop
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_REG,
        S_WR_IMM
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_instr;

    logic        r_w;
    logic [2:0]  r_readnum;
    logic [2:0]  r_writenum;
    logic        r_write;
    logic        r_loada;
    logic        r_loadb;
    logic        r_loadc;
    logic        r_loads;
    logic        r_asel;
    logic        r_vsel;

    logic [2:0]  w_opcode;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [2:0]  w_rm;
    logic        w_is_mov_imm;
    logic        w_is_mov_reg;
    logic        w_is_mvn;
    logic        w_is_alu3;
    logic        w_is_cmp;

    assign w_opcode = r_instr[15:13];
    assign w_op     = r_instr[12:11];
    assign w_rn     = r_instr[10:8];
    assign w_rd     = r_instr[7:5];
    assign w_rm     = r_instr[2:0];

    assign w_is_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_mvn     = (w_opcode == 3'b101) && (w_op == 2'b11);
    // ADD, CMP and AND are the two-operand forms that need GET_A
    assign w_is_alu3    = (w_opcode == 3'b101) && (w_op != 2'b11);
    assign w_is_cmp     = (w_opcode == 3'b101) && (w_op == 2'b01);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT:   w_next = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if (w_is_mov_imm)                 w_next = S_WR_IMM;
                else if (w_is_mov_reg || w_is_mvn) w_next = S_GET_B;
                else if (w_is_alu3)               w_next = S_GET_A;
                else                              w_next = S_WAIT;
            end
            S_GET_A:  w_next = S_GET_B;
            S_GET_B:  w_next = S_ALU;
            S_ALU:    w_next = w_is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: w_next = S_WAIT;
            S_WR_IMM: w_next = S_WAIT;
            default:  w_next = S_WAIT;
        endcase
    end

    // Outputs are registered by decoding the state being entered. The
    // instruction register only changes on the WAIT->DECODE edge, where all
    // instruction-dependent outputs are zero, so r_instr is already the
    // latched value whenever it is used here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_WAIT;
            r_instr    <= '0;
            r_w        <= 1'b1;
            r_readnum  <= '0;
            r_writenum <= '0;
            r_write    <= 1'b0;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_loadc    <= 1'b0;
            r_loads    <= 1'b0;
            r_asel     <= 1'b0;
            r_vsel     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT && s)
                r_instr <= in;

            r_w        <= (w_next == S_WAIT);
            r_readnum  <= '0;
            r_writenum <= '0;
            r_write    <= 1'b0;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_loadc    <= 1'b0;
            r_loads    <= 1'b0;
            r_asel     <= 1'b0;
            r_vsel     <= 1'b0;
            case (w_next)
                S_GET_A: begin
                    r_readnum <= w_rn;
                    r_loada   <= 1'b1;
                end
                S_GET_B: begin
                    r_readnum <= w_rm;
                    r_loadb   <= 1'b1;
                end
                S_ALU: begin
                    r_asel  <= w_is_mov_reg || w_is_mvn;
                    r_loadc <= !w_is_cmp;
                    r_loads <= w_is_cmp;
                end
                S_WR_REG: begin
                    r_writenum <= w_rd;
                    r_write    <= 1'b1;
                end
                S_WR_IMM: begin
                    r_writenum <= w_rn;
                    r_vsel     <= 1'b1;
                    r_write    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w        = r_w;
    assign readnum  = r_readnum;
    assign writenum = r_writenum;
    assign write    = r_write;
    assign loada    = r_loada;
    assign loadb    = r_loadb;
    assign loadc    = r_loadc;
    assign loads    = r_loads;
    assign asel     = r_asel;
    assign vsel     = r_vsel;
    assign sximm8   = {{8{r_instr[7]}}, r_instr[7:0]};
    assign shift    = r_instr[4:3];
    assign aluop    = r_instr[12:11];

endmodule

// File: tb/tb_sm_controller.sv
module tb_sm_controller;

    logic        clk;
    logic        reset;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        vsel;
    logic [15:0] sximm8;
    logic [1:0]  shift;
    logic [1:0]  aluop;

    sm_controller dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .in       (in),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .vsel     (vsel),
        .sximm8   (sximm8),
        .shift    (shift),
        .aluop    (aluop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        vsel;
        logic [15:0] sximm8;
        logic [1:0]  shift;
        logic [1:0]  aluop;
    } ctl_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ctl_t exp_q[$];
    ctl_t obs_q[$];

    function automatic ctl_t sample_dut();
        ctl_t c;
        c.w        = w;
        c.readnum  = readnum;
        c.writenum = writenum;
        c.write    = write;
        c.loada    = loada;
        c.loadb    = loadb;
        c.loadc    = loadc;
        c.loads    = loads;
        c.asel     = asel;
        c.vsel     = vsel;
        c.sximm8   = sximm8;
        c.shift    = shift;
        c.aluop    = aluop;
        return c;
    endfunction

    // Everything zero except the fields that mirror the latched word.
    function automatic ctl_t quiet(input logic [15:0] ins);
        ctl_t c;
        c        = '0;
        c.sximm8 = {{8{ins[7]}}, ins[7:0]};
        c.shift  = ins[4:3];
        c.aluop  = ins[12:11];
        return c;
    endfunction

    // Reference: expected output on each cycle following the accepting edge,
    // ending with the first cycle that is ready again.
    function automatic void build_expected(input logic [15:0] ins);
        ctl_t c;
        int unsigned opc, op;
        logic [2:0] rn, rd, rm;
        opc = ins[15:13];
        op  = ins[12:11];
        rn  = ins[10:8];
        rd  = ins[7:5];
        rm  = ins[2:0];
        exp_q.delete();
        exp_q.push_back(quiet(ins));
        if (opc == 6 && op == 2) begin
            c = quiet(ins); c.writenum = rn; c.vsel = 1; c.write = 1;
            exp_q.push_back(c);
        end else if ((opc == 6 && op == 0) || (opc == 5 && op == 3)) begin
            c = quiet(ins); c.readnum = rm; c.loadb = 1; exp_q.push_back(c);
            c = quiet(ins); c.asel = 1; c.loadc = 1;     exp_q.push_back(c);
            c = quiet(ins); c.writenum = rd; c.write = 1; exp_q.push_back(c);
        end else if (opc == 5) begin
            c = quiet(ins); c.readnum = rn; c.loada = 1; exp_q.push_back(c);
            c = quiet(ins); c.readnum = rm; c.loadb = 1; exp_q.push_back(c);
            c = quiet(ins); c.loadc = (op != 1); c.loads = (op == 1);
            exp_q.push_back(c);
            if (op != 1) begin
                c = quiet(ins); c.writenum = rd; c.write = 1; exp_q.push_back(c);
            end
        end
        c = quiet(ins); c.w = 1;
        exp_q.push_back(c);
    endfunction

    // Accept one instruction from the ready state and record the outputs for
    // as many cycles as the reference predicts. With noise, s and in are
    // scrambled while busy; the final drive leaves s low.
    task automatic run_instr(input logic [15:0] ins, input bit noise);
        build_expected(ins);
        obs_q.delete();
        in = ins;
        s  = 1'b1;
        @(negedge clk);
        s = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            obs_q.push_back(sample_dut());
            if (noise && i < exp_q.size() - 1) begin
                in = 16'($urandom);
                s  = 1'($urandom_range(0, 1));
            end else begin
                s = 1'b0;
            end
            if (i < exp_q.size() - 1)
                @(negedge clk);
        end
        s = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        ctl_t o;
        reset = 1'b1;
        s     = 1'b1;
        in    = 16'hD0FF;
        @(negedge clk);
        @(negedge clk);
        o = sample_dut();
        n_checks++;
        if (o !== quiet(16'h0000) + ctl_t'(34'h2_0000_0000)) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", o,
                     quiet(16'h0000) + ctl_t'(34'h2_0000_0000));
        end
        reset = 1'b0;
        s     = 1'b0;
        @(negedge clk);
        o = sample_dut();
        n_checks++;
        if (o.w !== 1'b1 || o.write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got w=%b write=%b exp w=1 write=0", o.w, o.write);
        end
    endtask

    task automatic test_mov_imm();
        run_instr(16'hD007, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL mov_imm cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (obs_q[0].w !== 1'b0 || obs_q[1].writenum !== 3'd0 || obs_q[1].vsel !== 1'b1 ||
            obs_q[1].sximm8 !== 16'h0007 || obs_q[1].write !== 1'b1 || obs_q[2].w !== 1'b1) begin
            n_fail++;
            $display("FAIL mov_imm_fields got wn=%0d vsel=%b imm=%h wr=%b w2=%b exp wn=0 vsel=1 imm=0007 wr=1 w2=1",
                     obs_q[1].writenum, obs_q[1].vsel, obs_q[1].sximm8, obs_q[1].write, obs_q[2].w);
        end
    endtask

    task automatic test_add();
        run_instr(16'hA140, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL add cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (obs_q[1].readnum !== 3'd1 || obs_q[1].loada !== 1'b1 ||
            obs_q[2].readnum !== 3'd0 || obs_q[2].loadb !== 1'b1 ||
            obs_q[3].loadc !== 1'b1 || obs_q[4].writenum !== 3'd2 ||
            obs_q[4].write !== 1'b1 || obs_q[4].w !== 1'b0 || obs_q[5].w !== 1'b1) begin
            n_fail++;
            $display("FAIL add_fields got rn1=%0d rn2=%0d wn=%0d w5=%b exp rn1=1 rn2=0 wn=2 w5=1",
                     obs_q[1].readnum, obs_q[2].readnum, obs_q[4].writenum, obs_q[5].w);
        end
    endtask

    task automatic test_cmp();
        bit wrote;
        run_instr(16'hA900, 1'b0);
        wrote = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL cmp cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i].write) wrote = 1'b1;
        end
        n_checks++;
        if (wrote || obs_q[3].loads !== 1'b1 || obs_q[3].loadc !== 1'b0 || obs_q[4].w !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp_fields got wrote=%b loads=%b loadc=%b w4=%b exp 0 1 0 1",
                     wrote, obs_q[3].loads, obs_q[3].loadc, obs_q[4].w);
        end
    endtask

    task automatic test_mvn_mov();
        run_instr(16'hB860, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL mvn cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (obs_q[2].asel !== 1'b1 || obs_q[3].writenum !== 3'd3 || obs_q[3].write !== 1'b1) begin
            n_fail++;
            $display("FAIL mvn_fields got asel=%b wn=%0d exp asel=1 wn=3", obs_q[2].asel, obs_q[3].writenum);
        end
        run_instr(16'hC080, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL mov_reg cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (obs_q[2].asel !== 1'b1 || obs_q[3].writenum !== 3'd4 || obs_q[3].write !== 1'b1) begin
            n_fail++;
            $display("FAIL mov_reg_fields got asel=%b wn=%0d exp asel=1 wn=4", obs_q[2].asel, obs_q[3].writenum);
        end
    endtask

    task automatic test_unsupported();
        run_instr(16'hE000, 1'b0);
        n_checks++;
        if (exp_q.size() != 2 || obs_q[0] !== quiet(16'hE000) || obs_q[1].w !== 1'b1 ||
            obs_q[1].write !== 1'b0 || obs_q[1].loada !== 1'b0 || obs_q[1].loadb !== 1'b0 ||
            obs_q[1].loadc !== 1'b0 || obs_q[1].loads !== 1'b0) begin
            n_fail++;
            $display("FAIL unsupported got c0=%h c1=%h exp c0=%h w1=1 no loads", obs_q[0], obs_q[1], quiet(16'hE000));
        end
    endtask

    task automatic test_reset_mid();
        ctl_t o;
        ctl_t e;
        in = 16'hA140;
        s  = 1'b1;
        @(negedge clk);
        s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        o = sample_dut();
        n_checks++;
        if (o.loadb !== 1'b1 || o.readnum !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_getb got loadb=%b rn=%0d exp loadb=1 rn=0", o.loadb, o.readnum);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        o = sample_dut();
        e = quiet(16'h0000);
        e.w = 1'b1;
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid got=%h exp=%h", o, e);
        end
        @(negedge clk);
        o = sample_dut();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_after got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        logic [15:0] last;
        ctl_t o;
        ctl_t e;
        last = 16'h0000;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: ins = {5'b11010, 11'($urandom)};
                1: ins = {5'b11000, 11'($urandom)};
                2: ins = {5'b10100, 11'($urandom)};
                3: ins = {5'b10101, 11'($urandom)};
                4: ins = {5'b10110, 11'($urandom)};
                5: ins = {5'b10111, 11'($urandom)};
                default: ins = 16'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                // stay idle a cycle; latched fields must persist
                in = 16'($urandom);
                s  = 1'b0;
                o  = sample_dut();
                e  = quiet(last);
                e.w = 1'b1;
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL rand_idle n=%0d got=%h exp=%h", n, o, e);
                end
                @(negedge clk);
            end
            run_instr(ins, 1'b1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand n=%0d ins=%h cyc=%0d got=%h exp=%h", n, ins, i, obs_q[i], exp_q[i]);
                end
            end
            last = ins;
        end
    endtask

    initial begin
        reset = 1'b1;
        s     = 1'b0;
        in    = 16'h0000;
        @(negedge clk);
        test_reset();
        test_mov_imm();
        test_add();
        test_cmp();
        test_mvn_mov();
        test_unsupported();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_controller.md
SM_CONTROLLER -- requirements
Module: sm_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  rising-edge clock shared with the register file and datapath.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 s  in  1  start request, sampled only in WAIT.
REQ-005 in  in  16  instruction word, captured when s is accepted.
REQ-006 w  out  1  ready; 1 only in WAIT.
REQ-007 readnum  out  3  register-file read index.
REQ-008 writenum  out  3  register-file write index.
REQ-009 write  out  1  register-file write enable, one cycle wide.
REQ-010 loada, loadb, loadc, loads  out  1 each  datapath A/B/C/status register enables.
REQ-011 asel  out  1  1 forces the ALU A input to zero.
REQ-012 vsel  out  1  write-back source: 0 is datapath C, 1 is sximm8.
REQ-013 sximm8  out  16  in[7:0] sign-extended, taken from the latched instruction.
REQ-014 shift  out  2  latched instr[4:3].
REQ-015 aluop  out  2  latched instr[12:11].

Function
REQ-016 The block SHALL latch `in` into an internal instruction register on the edge where the state is WAIT and s=1; the fields are:
- opcode = [15:13]
- op = [12:11]
- Rn = [10:8]
- Rd = [7:5]
- Rm = [2:0]
REQ-017 The latched instruction SHALL hold unchanged until the next accepted s; changes on `in` at other times SHALL have no effect.
REQ-018 The FSM SHALL be Moore with states WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM.
- WAIT: goes to DECODE when s=1, else stays in WAIT.
REQ-019 DECODE transitions by (opcode, op):
- 110,10 (MOV imm): to WR_IMM
- 110,00 (MOV reg): to GET_B
- 101,00 (ADD), 101,01 (CMP), 101,10 (AND): to GET_A
- 101,11 (MVN): to GET_B
- any other encoding: to WAIT, with no write and no load.
REQ-020 Further transitions:
- GET_A always goes to GET_B.
- GET_B always goes to ALU.
- ALU goes to WAIT for CMP and to WR_REG otherwise.
- WR_REG and WR_IMM always go to WAIT.
REQ-021 Per-state outputs (every output not listed is 0):
- WAIT: w=1
- GET_A: readnum=Rn, loada=1
- GET_B: readnum=Rm, loadb=1
- ALU: asel=1 for MOV reg and MVN; loadc=1 except for CMP; loads=1 for CMP only
- WR_REG: writenum=Rd, vsel=0, write=1
- WR_IMM: writenum=Rn, vsel=1, write=1
REQ-022 In all other states readnum and writenum SHALL drive 3'b000.
REQ-023 write SHALL be high for exactly one cycle per writing instruction and never for CMP or unsupported encodings.
REQ-024 Latency from the accepting edge back to w=1, in cycles:
- MOV imm: 2
- MOV reg: 4
- MVN: 4
- ADD: 5
- AND: 5
- CMP: 4
- unsupported: 1
REQ-025 An s asserted while not in WAIT SHALL be ignored; it is not queued.
REQ-026 sximm8, shift and aluop SHALL be combinational from the latched instruction register.

Reset
REQ-027 reset=1 at a rising edge SHALL force WAIT and clear the instruction register to 16'h0000 (sximm8=0, shift=0, aluop=0).
REQ-028 reset SHALL take priority over s and over every transition, including mid-instruction; no write SHALL occur on the cycle after reset is sampled.
REQ-029 After reset, w=1 and all other control outputs SHALL be 0.

Verification
REQ-030 in=16'hD007 (MOV R0,#7), s pulsed one cycle:
- WR_IMM cycle shows writenum=0, vsel=1, sximm8=16'h0007, write=1.
- w=1 two cycles after acceptance.
REQ-031 in=16'hA140 (ADD R2,R1,R0):
- readnum=1 with loada=1, then readnum=0 with loadb=1.
- Then loadc=1, then writenum=2 with write=1.
- w returns after 5 cycles.
REQ-032 in=16'hA900 (CMP R1,R0):
- loads=1 in ALU, loadc=0.
- write never asserted.
- w returns after 4 cycles.
REQ-033 in=16'hB860 (MVN R3,R0), then in=16'hC080 (MOV R4,R0):
- Each: asel=1 in ALU, write to 3 then 4.
- `in` changed mid-instruction does not alter writenum.
REQ-034 in=16'hE000 (unsupported): return to WAIT after 1 cycle; write and all loads remain 0.
REQ-035 Reset asserted during GET_B of an ADD: next state is WAIT, write stays 0, instruction register reads 0.
